// File: rtl/div_sequencer_if.sv
// Handshake bundle between the execute stage and the integer divide sequencer.
// The pipeline side drives the master modport; the divider takes the slave modport.
interface div_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Start;
    logic                  Flush;
    logic [1:0]            DivOp;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic [DATA_WIDTH-1:0] Result;
    logic                  Busy;
    logic                  Done;

    modport master (
        output Start, Flush, DivOp, SrcA, SrcB,
        input  Result, Busy, Done
    );

    modport slave (
        input  Start, Flush, DivOp, SrcA, SrcB,
        output Result, Busy, Done
    );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operates on magnitudes, one quotient bit per cycle, with the RISC-V sign fix applied on completion.
//
// state | meaning
// IDLE  | waiting for Start; Busy low
// RUN   | one shift/subtract step per cycle, count tracks remaining steps
// DONE  | Result valid, Done pulses for one cycle
module div_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    div_sequencer_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           load, div_zero, step, finish;

    logic [W-1:0]   rem_q, quo_q, divisor_q, result_q;
    logic [CW-1:0]  count_q;
    logic           is_rem_q, neg_q_q, neg_r_q;

    logic           is_signed;
    logic [W-1:0]   mag_a, mag_b;
    logic [W-1:0]   rem_shift, rem_next, quo_next, fixed_result;
    logic [W:0]     diff;

    assign is_signed = ~bus.DivOp[0];
    assign mag_a     = (is_signed && bus.SrcA[W-1]) ? -bus.SrcA : bus.SrcA;
    assign mag_b     = (is_signed && bus.SrcB[W-1]) ? -bus.SrcB : bus.SrcB;

    // A non-negative diff means the shifted remainder covers the divisor.
    assign rem_shift = {rem_q[W-2:0], quo_q[W-1]};
    assign diff      = {1'b0, rem_shift} - {1'b0, divisor_q};
    assign rem_next  = diff[W] ? rem_shift : diff[W-1:0];
    assign quo_next  = {quo_q[W-2:0], ~diff[W]};

    assign fixed_result = is_rem_q ? (neg_r_q ? -rem_next : rem_next)
                                   : (neg_q_q ? -quo_next : quo_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        div_zero = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.Flush && bus.Start) begin
                    if (bus.SrcB == '0) begin
                        div_zero = 1'b1;
                        state_d  = DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.Flush) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (count_q == CW'(1)) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            count_q   <= '0;
            is_rem_q  <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
        end else begin
            if (load) begin
                is_rem_q  <= bus.DivOp[1];
                neg_q_q   <= is_signed & (bus.SrcA[W-1] ^ bus.SrcB[W-1]);
                neg_r_q   <= is_signed & bus.SrcA[W-1];
                divisor_q <= mag_b;
                quo_q     <= mag_a;
                rem_q     <= '0;
                count_q   <= CW'(DATA_WIDTH);
            end
            // Divide by zero skips the sign fix: all ones for quotient, raw dividend for remainder.
            if (div_zero) begin
                result_q <= bus.DivOp[1] ? bus.SrcA : '1;
            end
            if (step) begin
                rem_q   <= rem_next;
                quo_q   <= quo_next;
                count_q <= count_q - CW'(1);
            end
            if (finish) begin
                result_q <= fixed_result;
            end
        end
    end

    assign bus.Result = result_q;
    assign bus.Busy   = (state_q != IDLE);
    assign bus.Done   = (state_q == DONE);
endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: scoreboard of expected results and latencies
// from an arithmetic reference model, compared when Done fires.
module tb_div_sequencer;
    logic clk;
    logic rst;

    div_sequencer_if #(.DATA_WIDTH(32)) bus ();

    div_sequencer #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_res[$];
    int          exp_lat[$];
    logic [31:0] last_res;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic drive_idle();
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        bus.DivOp = 2'($urandom);
        bus.SrcA  = $urandom;
        bus.SrcB  = $urandom;
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.Done) n++;
        end
    endtask

    // Issue one op; inj > 0 re-asserts Start at that cycle of the run to show it is ignored.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inj);
        int lat;
        bit busy_ok;
        logic [31:0] er;
        int el;
        exp_res.push_back(ref_div(op, a, b));
        exp_lat.push_back((b == 32'd0) ? 1 : 33);
        bus.Start = 1'b1;
        bus.DivOp = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.Done && lat < 100) begin
            if (!bus.Busy) busy_ok = 1'b0;
            if (lat == inj) begin
                bus.Start = 1'b1;
                bus.DivOp = 2'b01;
                bus.SrcA  = 32'd50;
                bus.SrcB  = 32'd5;
            end else begin
                bus.Start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.Start = 1'b0;
        er = exp_res.pop_front();
        el = exp_lat.pop_front();
        if (lat >= 100) begin
            chk({tag, "_timeout"}, 32'(bus.Done), 32'd1);
        end else begin
            chk({tag, "_result"}, bus.Result, er);
            chk({tag, "_latency"}, 32'(lat), 32'(el));
            chk({tag, "_busy"}, {31'd0, busy_ok & bus.Busy}, 32'd1);
            last_res = er;
        end
        @(negedge clk);
        chk({tag, "_pulse_end"}, {30'd0, bus.Busy, bus.Done}, 32'd0);
    endtask

    initial begin
        int n;
        logic [1:0] op;
        logic [31:0] a, b;

        rst = 1'b1;
        drive_idle();
        last_res = 32'd0;
        #1;
        chk("reset_result", bus.Result, 32'd0);
        chk("reset_flags", {30'd0, bus.Busy, bus.Done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu_100_7",   2'b01, 32'd100, 32'd7, 0);
        run_op("remu_100_7",   2'b11, 32'd100, 32'd7, 0);
        run_op("div_m100_7",   2'b00, -32'sd100, 32'd7, 0);
        run_op("rem_m100_7",   2'b10, -32'sd100, 32'd7, 0);
        run_op("rem_100_m7",   2'b10, 32'd100, -32'sd7, 0);
        run_op("div_ovf",      2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("divu_max_1",   2'b01, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("div_5_0",      2'b00, 32'd5, 32'd0, 0);
        run_op("remu_dz",      2'b11, 32'hDEAD_BEEF, 32'd0, 0);
        run_op("divu_big",     2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 0);

        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (b[31] && op[0] == 1'b0 && i == 3) b = 32'hFFFF_FFFD;
            run_op($sformatf("rand%0d", i), op, a, b, 0);
        end

        // Start during RUN must be ignored and produce exactly one Done.
        run_op("ign_start", 2'b01, 32'd100, 32'd7, 5);
        count_done(40, n);
        chk("ign_start_extra_done", 32'(n), 32'd0);

        // Flush ten cycles into RUN.
        bus.Start = 1'b1;
        bus.DivOp = 2'b01;
        bus.SrcA  = 32'd1000;
        bus.SrcB  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        for (int i = 1; i < 10; i++) @(negedge clk);
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        chk("flush_idle", {30'd0, bus.Busy, bus.Done}, 32'd0);
        chk("flush_result_kept", bus.Result, last_res);
        run_op("after_flush", 2'b01, 32'd9, 32'd3, 0);

        // Flush and Start together in IDLE: nothing starts.
        bus.Start = 1'b1;
        bus.Flush = 1'b1;
        bus.DivOp = 2'b01;
        bus.SrcA  = 32'd8;
        bus.SrcB  = 32'd2;
        @(negedge clk);
        drive_idle();
        chk("flush_start_busy", {31'd0, bus.Busy}, 32'd0);
        count_done(40, n);
        chk("flush_start_no_done", 32'(n), 32'd0);
        chk("flush_start_result", bus.Result, last_res);

        // Reset in the middle of RUN.
        bus.Start = 1'b1;
        bus.DivOp = 2'b00;
        bus.SrcA  = 32'd12345;
        bus.SrcB  = 32'd17;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        for (int i = 1; i < 10; i++) @(negedge clk);
        chk("pre_reset_busy", {31'd0, bus.Busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrun_reset_flags", {30'd0, bus.Busy, bus.Done}, 32'd0);
        chk("midrun_reset_result", bus.Result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done(40, n);
        chk("post_reset_no_done", 32'(n), 32'd0);
        last_res = 32'd0;

        run_op("post_reset_op", 2'b10, 32'd77, 32'd10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle integer divide controller for the execute stage, covering the RV32M DIV, DIVU, REM and REMU operations. It latches operands on a start pulse and runs a restoring-division loop, one subtract/compare per cycle. It then applies RISC-V sign and divide-by-zero rules and returns the result with a one-cycle done pulse. The hazard logic holds the pipeline while Busy is high.

## Interface
- DATA_WIDTH, 32, operand and result width; must be a power of two ≥ 8
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- Start  input  1  begin operation; sampled only in IDLE
- Flush  input  1  abort current operation (pipeline flush)
- DivOp  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; latched with Start
- SrcA  input  DATA_WIDTH  dividend; latched with Start
- SrcB  input  DATA_WIDTH  divisor; latched with Start
- Result  output  DATA_WIDTH  quotient or remainder; registered, held until next completion
- Busy  output  1  high in RUN and DONE
- Done  output  1  single-cycle pulse in DONE; Result valid that cycle

## Operation
- States: IDLE, RUN, DONE.
- IDLE, Start=1, Flush=0, SrcB≠0:
  - Latch DivOp.
  - Latch the magnitudes of SrcA/SrcB as dividend/divisor. Use two's-complement absolute value when DivOp[0]=0 (signed); use raw values when unsigned.
  - Record NegQ = signed & (SrcA[MSB] ^ SrcB[MSB]) and NegR = signed & SrcA[MSB].
  - Clear rem, load quo = dividend magnitude, set count = DATA_WIDTH, go to RUN.
- IDLE, Start=1, Flush=0, SrcB=0 (divide by zero):
  - Go to DONE directly.
  - Quotient result = all ones (DIV and DIVU); remainder result = SrcA unmodified (REM and REMU).
- RUN, each cycle:
  - rem' = {rem[W-2:0], quo[W-1]}; quo shifts left by 1.
  - diff = rem' − divisor, computed at W+1 bits.
  - If diff ≥ 0: rem = diff[W-1:0] and quo[0] = 1. Otherwise rem = rem' and quo[0] = 0.
  - Decrement count; when count reaches 1 in this cycle, go to DONE.
- Entering DONE:
  - Result = DivOp[1] ? (NegR ? −rem : rem) : (NegQ ? −quo : quo).
  - The divide-by-zero path bypasses the sign fix.
- DONE: Done=1 for exactly one cycle, then IDLE.
- Signed overflow (−2^(W−1) ÷ −1) needs no special path: quotient = 0x80000000, remainder = 0 (W=32), per RISC-V.
- Start in RUN or DONE is ignored, with no queuing.
- Flush in any state: go to IDLE on the next edge. Done is not asserted; Result keeps its previous value.
- Flush and Start in the same cycle in IDLE: Flush wins and the operation does not start.
- DivOp, SrcA and SrcB are don't-care outside the Start cycle.

## Timing
- Reset (async assert): state IDLE, Result = 0, Busy = 0, Done = 0, internal registers cleared. Release is synchronous to clk.
- Normal op: Start sampled at edge 0.
  - Busy=1 from edge 0 through edge DATA_WIDTH.
  - Done=1 and Result valid in the cycle after edge DATA_WIDTH, i.e. DATA_WIDTH+1 cycles after Start (33 for W=32).
  - Busy falls together with Done.
- Divide by zero: Done=1 in the cycle after the Start edge (latency 1).
- Back-to-back: a new Start is accepted in the first IDLE cycle after Done, giving a minimum issue interval of DATA_WIDTH+2 cycles.
- Outputs are registered or state-decoded only; no combinational path from inputs to outputs.
- Reset mid-RUN: outputs go to reset values immediately; no Done follows.

## Test plan
- DIVU 100 ÷ 7 → Done 33 cycles after Start, Result = 14. Repeat as REMU → Result = 2. Busy high for the whole interval.
- DIV −100 ÷ 7 → 0xFFFFFFF2 (−14). REM −100 ÷ 7 → 0xFFFFFFFE (−2). REM 100 ÷ −7 → 2.
- DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000. REM of the same operands → 0. DIVU 0xFFFFFFFF ÷ 1 → 0xFFFFFFFF.
- Divide by zero: DIV 5 ÷ 0 → 0xFFFFFFFF, REMU 0xDEADBEEF ÷ 0 → 0xDEADBEEF. Both give Done one cycle after Start.
- Flush at cycle 10 of RUN → IDLE next cycle, no Done, Result unchanged. Start in the cycle after the flush runs normally (DIVU 9 ÷ 3 → 3).
- Start asserted during RUN is ignored, giving exactly one Done. rst asserted mid-RUN → Busy = Done = Result = 0 immediately, and no Done occurs after release.
